// File: rtl/tlb_assoc.sv
// Set-associative TLB with tree-PLRU replacement, PCID tags, single-miss walker refill.
// Define TLB_STATS_EN to build the saturating hit/miss counters (otherwise tied to 0).
module tlb_assoc #(
  parameter int unsigned SADDR = 64,
  parameter int unsigned SPAGE = 12,
  parameter int unsigned NSET  = 8,
  parameter int unsigned NWAY  = 8,
  parameter int unsigned SPCID = 12,
  parameter int unsigned SCNT  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SADDR-1:0]       req_va,
  input  logic [SPCID-1:0]       req_pcid,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [SADDR-1:0]       resp_ta,
  output logic                   walk_valid,
  output logic [SADDR-1:0]       walk_va,
  output logic [SPCID-1:0]       walk_pcid,
  input  logic                   fill_valid,
  input  logic [SADDR-SPAGE-1:0] fill_ppn,
  input  logic                   flush,
  input  logic                   flush_by_pcid,
  input  logic [SPCID-1:0]       flush_pcid,
  output logic [SCNT-1:0]        hit_cnt,
  output logic [SCNT-1:0]        miss_cnt
);

  localparam int unsigned LS   = $clog2(NSET);
  localparam int unsigned LW   = $clog2(NWAY);
  localparam int unsigned STAG = SADDR - SPAGE - LS;
  localparam int unsigned SPPN = SADDR - SPAGE;

  typedef enum logic [1:0] {IDLE, LOOKUP, WALK, FLUSH} state_t;
  state_t state, state_nx;

  logic [SADDR-1:0] cap_va;
  logic [SPCID-1:0] cap_pcid;
  logic [LS-1:0]    set_idx;
  logic [STAG-1:0]  cap_tag;

  logic [NWAY-1:0]  vld    [NSET];
  logic [NWAY-2:0]  plru   [NSET];
  logic [STAG-1:0]  tag_q  [NSET][NWAY];
  logic [SPCID-1:0] pcid_q [NSET][NWAY];
  logic [SPPN-1:0]  ppn_q  [NSET][NWAY];

  logic             flush_pend, pend_by;
  logic [SPCID-1:0] pend_pcid;
  logic             fl_by;
  logic [SPCID-1:0] fl_pcid;
  logic [LS-1:0]    fl_set;

  logic          hit, has_free, b;
  logic [LW-1:0] hit_way, free_way, tree_way, victim, node;

  assign set_idx    = cap_va[SPAGE+LS-1:SPAGE];
  assign cap_tag    = cap_va[SADDR-1:SPAGE+LS];
  assign req_ready  = (state == IDLE) && !flush && !flush_pend;
  assign walk_valid = (state == WALK);
  assign walk_va    = cap_va;
  assign walk_pcid  = cap_pcid;

  // Each level points away from the way just used; heap children of n are 2n+1 / 2n+2.
  function automatic logic [NWAY-2:0] plru_upd(input logic [NWAY-2:0] cur,
                                               input logic [LW-1:0]   w);
    logic [NWAY-2:0] t;
    logic [LW-1:0]   nd, ws;
    logic            d;
    t  = cur;
    nd = '0;
    ws = w;
    for (int unsigned l = 0; l < LW; l++) begin
      d     = ws[LW-1];
      t[nd] = ~d;
      nd    = LW'({nd, d} + (LW+1)'(1));
      ws    = ws << 1;
    end
    return t;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NWAY; w++) begin
      if (!hit && vld[set_idx][w] && tag_q[set_idx][w] == cap_tag &&
          pcid_q[set_idx][w] == cap_pcid) begin
        hit     = 1'b1;
        hit_way = LW'(w);
      end
    end
  end

  // Leaf k is way k, so the bits followed from the root spell the victim index MSB-first.
  always_comb begin
    has_free = 1'b0;
    free_way = '0;
    for (int unsigned w = 0; w < NWAY; w++) begin
      if (!has_free && !vld[set_idx][w]) begin
        has_free = 1'b1;
        free_way = LW'(w);
      end
    end
    node     = '0;
    tree_way = '0;
    b        = 1'b0;
    for (int unsigned l = 0; l < LW; l++) begin
      b        = plru[set_idx][node];
      tree_way = LW'({tree_way, b});
      node     = LW'({node, b} + (LW+1)'(1));
    end
    victim = has_free ? free_way : tree_way;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (flush || flush_pend) state_nx = FLUSH;
               else if (req_valid)      state_nx = LOOKUP;
      LOOKUP:  state_nx = hit ? IDLE : WALK;
      WALK:    if (fill_valid) state_nx = IDLE;
      FLUSH:   if (fl_set == LS'(NSET-1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cap_va     <= '0;
      cap_pcid   <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_ta    <= '0;
      flush_pend <= 1'b0;
      pend_by    <= 1'b0;
      pend_pcid  <= '0;
      fl_by      <= 1'b0;
      fl_pcid    <= '0;
      fl_set     <= '0;
      for (int unsigned s = 0; s < NSET; s++) begin
        vld[s]  <= '0;
        plru[s] <= '0;
      end
    end else begin
      state      <= state_nx;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush || flush_pend) begin
            fl_by      <= flush ? flush_by_pcid : pend_by;
            fl_pcid    <= flush ? flush_pcid : pend_pcid;
            fl_set     <= '0;
            flush_pend <= 1'b0;
          end else if (req_valid) begin
            cap_va   <= req_va;
            cap_pcid <= req_pcid;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid    <= 1'b1;
            resp_hit      <= 1'b1;
            resp_ta       <= {ppn_q[set_idx][hit_way], cap_va[SPAGE-1:0]};
            plru[set_idx] <= plru_upd(plru[set_idx], hit_way);
          end
        end
        WALK: begin
          if (fill_valid) begin
            vld[set_idx][victim] <= 1'b1;
            plru[set_idx]        <= plru_upd(plru[set_idx], victim);
            resp_valid           <= 1'b1;
            resp_hit             <= 1'b0;
            resp_ta              <= {fill_ppn, cap_va[SPAGE-1:0]};
          end
        end
        FLUSH: begin
          for (int unsigned w = 0; w < NWAY; w++) begin
            if (!fl_by || pcid_q[fl_set][w] == fl_pcid) vld[fl_set][w] <= 1'b0;
          end
          if (!fl_by) plru[fl_set] <= '0;
          fl_set <= fl_set + LS'(1);
        end
        default: ;
      endcase
      // Flushes arriving while busy are held; a later one replaces an earlier one.
      if (state != IDLE && flush) begin
        flush_pend <= 1'b1;
        pend_by    <= flush_by_pcid;
        pend_pcid  <= flush_pcid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == WALK && fill_valid) begin
      tag_q[set_idx][victim]  <= cap_tag;
      pcid_q[set_idx][victim] <= cap_pcid;
      ppn_q[set_idx][victim]  <= fill_ppn;
    end
  end

`ifdef TLB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit && hit_cnt != '1)   hit_cnt  <= hit_cnt + SCNT'(1);
      if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + SCNT'(1);
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_tlb_assoc.sv
// Scoreboard bench for tlb_assoc (NWAY=4): a reference TLB model predicts each response.
module tb_tlb_assoc;
  localparam int SADDR = 64, SPAGE = 12, NSET = 8, NWAY = 4, SPCID = 12, SCNT = 32;
  localparam int LS = 3, LW = 2;

  logic clk, rst, req_valid, req_ready, resp_valid, resp_hit, walk_valid;
  logic fill_valid, flush, flush_by_pcid;
  logic [63:0] req_va, resp_ta, walk_va;
  logic [11:0] req_pcid, walk_pcid, flush_pcid;
  logic [51:0] fill_ppn;
  logic [31:0] hit_cnt, miss_cnt;

  tlb_assoc #(.SADDR(SADDR), .SPAGE(SPAGE), .NSET(NSET), .NWAY(NWAY),
              .SPCID(SPCID), .SCNT(SCNT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_va(req_va), .req_pcid(req_pcid), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_ta(resp_ta), .walk_valid(walk_valid),
    .walk_va(walk_va), .walk_pcid(walk_pcid), .fill_valid(fill_valid),
    .fill_ppn(fill_ppn), .flush(flush), .flush_by_pcid(flush_by_pcid),
    .flush_pcid(flush_pcid), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  typedef struct { bit hit; logic [63:0] ta; int cyc; } exp_t;
  exp_t sbq[$];
  bit          last_hit;
  logic [63:0] last_ta;

  // Reference model: plain arrays of entries plus explicit PLRU node bits per set.
  bit          m_v    [NSET][NWAY];
  logic [63:0] m_tag  [NSET][NWAY];
  logic [11:0] m_pcid [NSET][NWAY];
  logic [51:0] m_ppn  [NSET][NWAY];
  bit          m_plru [NSET][NWAY-1];
  logic [31:0] mh, mm;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_to(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [31:0] sat(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < NSET; s++) begin
      for (int w = 0; w < NWAY; w++) m_v[s][w] = 0;
      for (int k = 0; k < NWAY-1; k++) m_plru[s][k] = 0;
    end
    mh = 0;
    mm = 0;
  endfunction

  function automatic int m_find(input int s, input logic [63:0] tg, input logic [11:0] p);
    for (int w = 0; w < NWAY; w++)
      if (m_v[s][w] && m_tag[s][w] == tg && m_pcid[s][w] == p) return w;
    return -1;
  endfunction

  function automatic int m_victim(input int s);
    int nd = 0;
    for (int w = 0; w < NWAY; w++) if (!m_v[s][w]) return w;
    while (nd < NWAY-1) nd = 2*nd + 1 + int'(m_plru[s][nd]);
    return nd - (NWAY-1);
  endfunction

  function automatic void m_touch(input int s, input int w);
    int nd = 0;
    int d;
    for (int l = LW-1; l >= 0; l--) begin
      d = (w >> l) & 1;
      m_plru[s][nd] = (d == 0);
      nd = 2*nd + 1 + d;
    end
  endfunction

  function automatic void m_flush(input bit by, input logic [11:0] p);
    for (int s = 0; s < NSET; s++) begin
      for (int w = 0; w < NWAY; w++) if (!by || m_pcid[s][w] == p) m_v[s][w] = 0;
      if (!by) for (int k = 0; k < NWAY-1; k++) m_plru[s][k] = 0;
    end
  endfunction

  task automatic chk_cnt();
`ifdef TLB_STATS_EN
    chk("hit_cnt", hit_cnt, mh);
    chk("miss_cnt", miss_cnt, mm);
`else
    chk("hit_cnt", hit_cnt, 0);
    chk("miss_cnt", miss_cnt, 0);
`endif
  endtask

  // Monitor: every response must match the oldest expectation, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_resp: got resp_ta 0x%0h expected no response (cycle %0d)",
                   resp_ta, cyc);
        end else begin
          e = sbq.pop_front();
          chk("resp_hit", resp_hit, e.hit);
          chk("resp_ta", resp_ta, e.ta);
          chk("resp_cycle", cyc, e.cyc);
        end
        last_hit = resp_hit;
        last_ta  = resp_ta;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Called shortly after a negedge; returns at the negedge after the accepting edge n.
  task automatic accept(input logic [63:0] va, input logic [11:0] p, output int n, output bit ok);
    int g = 0;
    req_valid = 1;
    req_va    = va;
    req_pcid  = p;
    #1;
    while (!req_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    ok = req_ready;
    n  = cyc + 1;
    if (!ok) begin
      fail_to("req_ready");
      req_valid = 0;
      return;
    end
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic do_req(input logic [63:0] va, input logic [11:0] p, input int dly_in,
                        input bit use_ppn, input logic [51:0] fppn,
                        input bit fl_mid, input bit fby, input logic [11:0] fpc);
    int s, way, n, g, f, cnt, dly, w;
    logic [63:0] tg;
    logic [51:0] ppn;
    bit ok;
    exp_t e;
    s   = int'((va >> SPAGE) % NSET);
    tg  = va >> (SPAGE + LS);
    way = m_find(s, tg, p);
    accept(va, p, n, ok);
    if (!ok) return;
    if (way >= 0) begin
      e.hit = 1;
      e.ta  = {m_ppn[s][way], va[11:0]};
      e.cyc = n + 1;
      sbq.push_back(e);
      mh = sat(mh);
      m_touch(s, way);
      @(negedge clk);
      #1;
      if (walk_valid) begin
        fill_valid = 1;
        fill_ppn   = '0;
        @(negedge clk);
        fill_valid = 0;
        #1;
      end
      return;
    end
    mm = sat(mm);
    g  = 0;
    while (!walk_valid && g < 4) begin
      @(negedge clk);
      g++;
    end
    if (!walk_valid) begin
      fail_to("walk_valid");
      return;
    end
    chk("walk_start", cyc, n + 1);
    chk("walk_va", walk_va, va);
    chk("walk_pcid", walk_pcid, p);
    if (fl_mid) begin
      flush = 1;
      flush_by_pcid = fby;
      flush_pcid = fpc;
      @(negedge clk);
      flush = 0;
    end
    ppn = use_ppn ? fppn : 52'({$urandom(), $urandom()});
    dly = (dly_in < 0) ? int'($urandom_range(0, 3)) : dly_in;
    repeat (dly) @(negedge clk);
    chk("walk_hold", walk_valid, 1);
    fill_valid = 1;
    fill_ppn   = ppn;
    f = cyc + 1;
    w = m_victim(s);
    m_v[s][w] = 1;
    m_tag[s][w] = tg;
    m_pcid[s][w] = p;
    m_ppn[s][w] = ppn;
    m_touch(s, w);
    e.hit = 0;
    e.ta  = {ppn, va[11:0]};
    e.cyc = f;
    sbq.push_back(e);
    @(negedge clk);
    fill_valid = 0;
    if (fl_mid) begin
      cnt = 0;
      #1;
      while (!req_ready && cnt < 100) begin
        cnt++;
        @(negedge clk);
        #1;
      end
      chk("flush_len_pending", cnt, NSET + 1);
      m_flush(fby, fpc);
    end
    #1;
  endtask

  task automatic do_flush(input bit by, input logic [11:0] p);
    int cnt = 0;
    flush = 1;
    flush_by_pcid = by;
    flush_pcid = p;
    #1;
    while (!req_ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
      flush = 0;
      #1;
    end
    flush = 0;
    chk("flush_len_idle", cnt, NSET + 1);
    m_flush(by, p);
  endtask

  function automatic logic [63:0] mkva(input logic [48:0] tg, input int s, input logic [11:0] off);
    return {tg, 3'(s), off};
  endfunction

  initial begin
    logic [63:0] va_a, va_b, va_r;
    logic [11:0] pc;
    logic [48:0] tg;
    int n;
    bit ok;
    rst = 1; req_valid = 0; req_va = '0; req_pcid = '0;
    fill_valid = 0; fill_ppn = '0; flush = 0; flush_by_pcid = 0; flush_pcid = '0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_walk_valid", walk_valid, 0);
    chk("rst_walk_va", walk_va, 0);
    chk("rst_resp_ta", resp_ta, 0);
    chk_cnt();

    // Cold miss, then hit, then PCID isolation
    va_a = 64'h0000_0000_0040_1ABC;
    do_req(va_a, 12'd3, 2, 1, 52'h77, 0, 0, '0);
    chk("cold_hit", last_hit, 0);
    chk("cold_ta", last_ta, 64'h77ABC);
    chk_cnt();
    do_req(va_a, 12'd3, -1, 0, '0, 0, 0, '0);
    chk("rehit_hit", last_hit, 1);
    chk("rehit_ta", last_ta, 64'h77ABC);
    chk_cnt();
    do_req(va_a, 12'd4, -1, 0, '0, 0, 0, '0);
    chk("pcid4_miss", last_hit, 0);
    do_req(va_a, 12'd3, -1, 0, '0, 0, 0, '0);
    chk("pcid3_still_hit", last_hit, 1);
    do_req(va_a, 12'd4, -1, 0, '0, 0, 0, '0);
    chk("pcid4_hit", last_hit, 1);

    // PLRU eviction in set 0: fill ways 0..3, touch ways 0 and 2, new tag evicts way 1
    do_flush(0, '0);
    for (int t = 1; t <= 4; t++) do_req(mkva(49'(t), 0, 12'h010), 12'd3, -1, 0, '0, 0, 0, '0);
    do_req(mkva(49'd1, 0, 12'h020), 12'd3, -1, 0, '0, 0, 0, '0);
    do_req(mkva(49'd3, 0, 12'h030), 12'd3, -1, 0, '0, 0, 0, '0);
    do_req(mkva(49'd5, 0, 12'h040), 12'd3, -1, 0, '0, 0, 0, '0);
    chk("plru_new_miss", last_hit, 0);
    do_req(mkva(49'd1, 0, 12'h050), 12'd3, -1, 0, '0, 0, 0, '0);
    chk("plru_way0_kept", last_hit, 1);
    do_req(mkva(49'd3, 0, 12'h060), 12'd3, -1, 0, '0, 0, 0, '0);
    chk("plru_way2_kept", last_hit, 1);
    do_req(mkva(49'd4, 0, 12'h070), 12'd3, -1, 0, '0, 0, 0, '0);
    chk("plru_way3_kept", last_hit, 1);
    do_req(mkva(49'd2, 0, 12'h080), 12'd3, -1, 0, '0, 0, 0, '0);
    chk("plru_way1_evicted", last_hit, 0);

    // PCID flush issued during a walk
    do_req(va_a, 12'd3, -1, 0, '0, 0, 0, '0);
    do_req(va_a, 12'd4, -1, 0, '0, 0, 0, '0);
    va_b = mkva(49'h1_2345, 2, 12'h444);
    do_req(va_b, 12'd3, 1, 0, '0, 1, 1, 12'd3);
    chk("fmid_fill_completed", last_hit, 0);
    do_req(va_a, 12'd4, -1, 0, '0, 0, 0, '0);
    chk("fpcid_other_kept", last_hit, 1);
    do_req(va_a, 12'd3, -1, 0, '0, 0, 0, '0);
    chk("fpcid_flushed", last_hit, 0);
    chk_cnt();

    // Reset in the middle of a walk
    va_r = mkva(49'h0ABC, 5, 12'h123);
    accept(va_r, 12'd5, n, ok);
    repeat (2) @(negedge clk);
    chk("pre_rst_walk", walk_valid, 1);
    rst = 1;
    #1;
    chk("arst_walk_valid", walk_valid, 0);
    chk("arst_walk_va", walk_va, 0);
    chk("arst_walk_pcid", walk_pcid, 0);
    chk("arst_resp_ta", resp_ta, 0);
    chk("arst_resp_hit", resp_hit, 0);
    chk("arst_req_ready", req_ready, 1);
    m_reset();
    chk_cnt();
    @(negedge clk);
    rst = 0;
    fill_valid = 1;
    fill_ppn = 52'hDEAD;
    @(negedge clk);
    fill_valid = 0;
    repeat (3) @(negedge clk);
    #1;
    do_req(va_a, 12'd4, -1, 0, '0, 0, 0, '0);
    chk("post_rst_miss", last_hit, 0);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      pc = 12'(3 + $urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) begin
        do_flush(1'($urandom_range(0, 1)), pc);
      end else begin
        tg = 49'($urandom_range(0, 9));
        if ($urandom_range(0, 3) == 0) tg = tg | 49'h1_0000_0000_0000;
        do_req(mkva(tg, int'($urandom_range(0, NSET-1)), 12'($urandom())), pc, -1, 0, '0,
               $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
               12'(3 + $urandom_range(0, 2)));
      end
      if (i % 50 == 49) chk_cnt();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    chk_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tlb_assoc.md
# tlb_assoc

Parametrised set-associative TLB with tree-PLRU replacement, per-entry valid bits, PCID tagging, and a single-outstanding-miss refill handshake to the page walker. It sits between the core's address-generation stage and the page-table walker. It supersedes the fixed 8-way/8-set translation cache with:
- arbitrary power-of-two way and set counts;
- asynchronous reset;
- valid/ready request flow;
- sequential full or per-PCID flush.

## Interface
- SADDR, 64, virtual/physical address width
- SPAGE, 12, page-offset width
- NSET, 8, sets (power of two, ≥2)
- NWAY, 8, ways (power of two, ≥2); PLRU tree holds NWAY-1 bits per set
- SPCID, 12, PCID width
- SCNT, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  lookup request
- req_ready  out  1  block accepts a request
- req_va  in  SADDR  virtual address
- req_pcid  in  SPCID  process-context identifier
- resp_valid  out  1  one-cycle result pulse
- resp_hit  out  1  1 = TLB hit, 0 = result came from refill
- resp_ta  out  SADDR  translated address
- walk_valid  out  1  miss request to walker; level signal
- walk_va  out  SADDR  captured VA of the missing request
- walk_pcid  out  SPCID  captured PCID of the missing request
- fill_valid  in  1  walker returns the PPN
- fill_ppn  in  SADDR-SPAGE  physical page number
- flush  in  1  flush request pulse
- flush_by_pcid  in  1  qualifies flush: 0 = all entries, 1 = entries matching flush_pcid
- flush_pcid  in  SPCID  PCID to flush
- hit_cnt  out  SCNT  hit counter
- miss_cnt  out  SCNT  miss counter

## Operation

Address fields: set = va[SPAGE+log2(NSET)-1:SPAGE]; tag = va[SADDR-1:SPAGE+log2(NSET)].

Entry contents per (set, way): valid, tag, pcid, ppn. A hit requires valid, tag match and pcid match.

States:
- IDLE:
  - req_ready=1.
  - A pending flush is taken before a request.
  - Otherwise req_valid captures va/pcid and the state moves to LOOKUP.
- LOOKUP:
  - Compare all ways of the captured set.
  - Hit:
    - resp_valid=1, resp_hit=1, resp_ta={ppn, va[SPAGE-1:0]};
    - update PLRU; go to IDLE.
  - Miss: go to WALK.
- WALK:
  - walk_valid=1; walk_va and walk_pcid hold the captured values.
  - On fill_valid:
    - write the victim way: valid=1, tag, pcid, ppn=fill_ppn;
    - update PLRU;
    - resp_valid=1, resp_hit=0, resp_ta={fill_ppn, offset};
    - go to IDLE.
- FLUSH:
  - Visit set 0..NSET-1, one set per cycle.
  - Clear valid of every way (flush_by_pcid=0), or only of ways whose pcid equals the latched flush_pcid.
  - A full flush also zeroes that set's PLRU bits.
  - After set NSET-1, go to IDLE.

Victim selection, in priority order:
- The lowest-index invalid way in the set.
- Otherwise the PLRU victim: start at node 0 and follow the bits (0 = left, 1 = right); the children of node i are 2i+1 and 2i+2; leaf k is way k.

PLRU update on a hit or fill to way w: every node on the root-to-w path is set to point away from w.

Flush handling:
- A flush arriving outside IDLE is latched (flush_by_pcid and flush_pcid are sampled with it) and taken on the next IDLE cycle.
- The in-flight request completes normally.
- A second flush while one is pending overwrites the pending flush.

Counters:
- hit_cnt increments on each hit response.
- miss_cnt increments on each LOOKUP→WALK transition.
- Both saturate at all-ones.

Input rules:
- fill_valid outside WALK is ignored.
- The requester must hold req_va and req_pcid stable while req_valid=1 and req_ready=0.
- Only one request is outstanding at a time.

## Timing
- Reset values:
  - state IDLE; req_ready=1 (combinational from state);
  - resp_valid, resp_hit, resp_ta, walk_valid, walk_va, walk_pcid = 0;
  - all valid bits and PLRU bits = 0;
  - hit_cnt = miss_cnt = 0; pending flush cleared.
- Tag, pcid and ppn arrays are not reset.
- Reset asserted mid-WALK or mid-FLUSH aborts the operation: no response is produced and all entries become invalid.
- Request accepted at edge N: LOOKUP occupies cycle N+1.
  - Hit: resp_valid is high in cycle N+2 only.
- Miss: walk_valid is high from cycle N+2 until the cycle in which fill_valid is sampled high (edge F).
  - resp_valid is high in cycle F+1.
  - The entry is visible to a lookup accepted at F+1 or later.
- req_ready is 0 in LOOKUP, WALK and FLUSH. A new request can be accepted in the cycle resp_valid is high.
- Flush: NSET cycles in FLUSH, plus 1 cycle of IDLE entry if it was pending.
- Throughput on back-to-back hits: one response every 2 cycles.

## Configuration
- TLB_STATS_EN:
  - Defined: hit_cnt and miss_cnt count as described.
  - Undefined: counter logic is not built; both ports are tied to 0 and the ports remain present.

## Test plan
- Cold miss:
  - Stimulus: after reset, request va=0x0000_0000_0040_1ABC, pcid=3; answer fill_ppn=0x77 two cycles after walk_valid.
  - Response: walk_va matches the request; resp_valid with resp_hit=0, resp_ta=0x77ABC; miss_cnt=1.
- Hit after fill: repeating the same request gives resp_hit=1, resp_ta=0x77ABC, resp_valid exactly 2 cycles after acceptance, hit_cnt=1.
- PCID isolation: the same va with pcid=4 misses; after refilling it, both pcid 3 and pcid 4 hit.
- PLRU eviction (NWAY=4):
  - Stimulus: fill ways 0..3 of set 0, then hit way 0 and way 2, then miss on a new tag in set 0.
  - Response: the new entry replaces way 1; a request to the old way-1 tag misses.
- Flush by PCID:
  - Stimulus: flush_by_pcid=1, flush_pcid=3, issued while in WALK.
  - Response: the pending fill completes; FLUSH then lasts NSET cycles; pcid 3 entries miss and pcid 4 entries still hit.
- Reset mid-WALK: assert rst while walk_valid=1. All outputs return to 0 immediately, a later fill_valid produces no response, and previously valid entries miss.
